// File: rtl/axil_chan_pkg.sv
// Shared register-map constants and field layouts for the AXI-lite channel
// register interface.
package axil_chan_pkg;

  localparam logic [3:0]  OFF_CTRL    = 4'h0;
  localparam logic [3:0]  OFF_TX_DATA = 4'h4;
  localparam logic [3:0]  OFF_RX_DATA = 4'h8;
  localparam logic [3:0]  OFF_STATUS  = 4'hC;
  localparam logic [31:0] ADDR_ID     = 32'h0000_0100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_BCH_BIT    = 0;
  localparam int unsigned CTRL_FS_BIT     = 1;
  localparam int unsigned CTRL_GAUSS_BIT  = 2;
  localparam int unsigned CTRL_BER_BIT    = 3;
  localparam int unsigned CTRL_DENS_LSB   = 8;
  localparam int unsigned CTRL_BERGEN_LSB = 16;

  localparam int unsigned STATUS_OVF_BIT = 2;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  count;
    logic [3:0]  rsvd_lo;
    logic        tx_busy;
    logic        overflow;
    logic        full;
    logic        empty;
  } status_t;

endpackage

// File: rtl/axil_chan_regif_rx_fifo.sv
// Per-channel receive FIFO; a push into a full FIFO is dropped and flagged
// unless a pop frees a slot in the same cycle.
module chan_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axil_chan_regif.sv
// AXI-lite register slave exposing per-channel CTRL, a one-deep TX byte
// slot, an RX FIFO and STATUS, plus a read-only ID register.
module axil_chan_regif
  import axil_chan_pkg::*;
#(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'hBC40_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [ADDR_W-1:0]     s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  input  logic [ADDR_W-1:0]     s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic [NUM_CH*32-1:0]  ch_cfg,
  output logic [NUM_CH*8-1:0]   ch_tx_data,
  output logic [NUM_CH-1:0]     ch_tx_valid,
  input  logic [NUM_CH-1:0]     ch_tx_ready,
  input  logic [NUM_CH*8-1:0]   ch_rx_data,
  input  logic [NUM_CH-1:0]     ch_rx_valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic       hit_id;
    logic       hit_ch;
    logic [2:0] ch;
    logic [3:0] off;
  } dec_t;

  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t d;
    d.hit_id = (a == ADDR_W'(ADDR_ID));
    d.hit_ch = (a[ADDR_W-1:4] < (ADDR_W-4)'(NUM_CH));
    d.ch     = a[6:4];
    d.off    = a[3:0];
    return d;
  endfunction

  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       cfg_q [NUM_CH];
  logic [31:0]       cfg_d [NUM_CH];
  logic [7:0]        txd_q [NUM_CH];
  logic [7:0]        txd_d [NUM_CH];
  logic [NUM_CH-1:0] txv_q, txv_d, ovf_q, ovf_d, ovf_clr;
  logic [NUM_CH-1:0] pop, empty, full, drop;
  logic [7:0]        rx_dout [NUM_CH];
  logic [CW-1:0]     rx_cnt [NUM_CH];
  dec_t              wdec, rdec;
  status_t           st;
  logic              unused_prot;

  assign unused_prot    = ^{s_axil_awprot, s_axil_arprot};
  assign s_axil_awready = !aw_held_q && !bvalid_q;
  assign s_axil_wready  = !w_held_q && !bvalid_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign ch_tx_valid    = txv_q;

  always_comb begin
    ch_cfg     = '0;
    ch_tx_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_cfg[c*32 +: 32]   = cfg_q[c];
      ch_tx_data[c*8 +: 8] = txd_q[c];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    chan_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ch_rx_valid[g]),
      .din_i   (ch_rx_data[g*8 +: 8]),
      .pop_i   (pop[g]),
      .dout_o  (rx_dout[g]),
      .count_o (rx_cnt[g]),
      .empty_o (empty[g]),
      .full_o  (full[g]),
      .drop_o  (drop[g])
    );
  end

  always_comb begin
    aw_held_d = aw_held_q;  awaddr_d = awaddr_q;
    w_held_d  = w_held_q;   wdata_d  = wdata_q;   wstrb_d = wstrb_q;
    bvalid_d  = bvalid_q;   bresp_d  = bresp_q;
    rvalid_d  = rvalid_q;   rresp_d  = rresp_q;   rdata_d = rdata_q;
    cfg_d     = cfg_q;      txd_d    = txd_q;     txv_d   = txv_q;
    ovf_clr   = '0;         pop      = '0;        st      = '0;
    wdec      = decode(awaddr_q);
    rdec      = decode(s_axil_araddr);

    if (s_axil_awvalid && s_axil_awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (txv_q[c] && ch_tx_ready[c]) txv_d[c] = 1'b0;

    // Defaulting the response to SLVERR makes every unmatched decode an error with no side effect.
    if (aw_held_q && w_held_q && !bvalid_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wdec.hit_ch && wdec.ch == 3'(c)) begin
          case (wdec.off)
            OFF_CTRL: begin
              for (int unsigned b = 0; b < 4; b++)
                if (wstrb_q[b]) cfg_d[c][8*b +: 8] = wdata_q[8*b +: 8];
              bresp_d = RESP_OKAY;
            end
            OFF_TX_DATA: begin
              if (wstrb_q[0] && !txv_q[c]) begin
                txd_d[c] = wdata_q[7:0];
                txv_d[c] = 1'b1;
                bresp_d  = RESP_OKAY;
              end
            end
            OFF_STATUS: begin
              ovf_clr[c] = wstrb_q[0] && wdata_q[STATUS_OVF_BIT];
              bresp_d    = RESP_OKAY;
            end
            default: ;
          endcase
        end
      end
    end

    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (s_axil_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_SLVERR;
      rdata_d  = '0;
      if (rdec.hit_id) begin
        rresp_d = RESP_OKAY;
        rdata_d = ID_VALUE;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rdec.hit_ch && rdec.ch == 3'(c)) begin
          case (rdec.off)
            OFF_CTRL: begin
              rresp_d = RESP_OKAY;
              rdata_d = cfg_q[c];
            end
            OFF_RX_DATA: begin
              rresp_d = RESP_OKAY;
              if (!empty[c]) begin
                rdata_d = {1'b1, 23'b0, rx_dout[c]};
                pop[c]  = 1'b1;
              end
            end
            OFF_STATUS: begin
              st.empty    = empty[c];
              st.full     = full[c];
              st.overflow = ovf_q[c];
              st.tx_busy  = txv_q[c];
              st.count    = 4'(rx_cnt[c]);
              rresp_d     = RESP_OKAY;
              rdata_d     = st;
            end
            default: ;
          endcase
        end
      end
    end

    // A drop in the same cycle as a W1C wins so the event is never lost.
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      cfg_q     <= '{default: '0};
      txd_q     <= '{default: '0};
      txv_q     <= '0;
      ovf_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      cfg_q     <= cfg_d;
      txd_q     <= txd_d;
      txv_q     <= txv_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_axil_chan_regif.sv
// Directed bench for axil_chan_regif: register map, handshakes, RX FIFO
// corner cases and mid-transaction reset.
module tb_axil_chan_regif;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              awvalid = 1'b0, awready;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [2:0]        awprot = '0;
  logic              wvalid = 1'b0, wready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              bvalid, bready = 1'b0;
  logic [1:0]        bresp;
  logic              arvalid = 1'b0, arready;
  logic [ADDR_W-1:0] araddr = '0;
  logic [2:0]        arprot = '0;
  logic              rvalid, rready = 1'b0;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic [NUM_CH*32-1:0] ch_cfg;
  logic [NUM_CH*8-1:0]  ch_tx_data;
  logic [NUM_CH-1:0]    ch_tx_valid;
  logic [NUM_CH-1:0]    ch_tx_ready = '0;
  logic [NUM_CH*8-1:0]  ch_rx_data = '0;
  logic [NUM_CH-1:0]    ch_rx_valid = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  axil_chan_regif #(
    .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(8), .ID_VALUE(32'hBC40_0001)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_awprot(awprot),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_arprot(arprot),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .ch_cfg(ch_cfg), .ch_tx_data(ch_tx_data), .ch_tx_valid(ch_tx_valid),
    .ch_tx_ready(ch_tx_ready), .ch_rx_data(ch_rx_data), .ch_rx_valid(ch_rx_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int unsigned n;
    logic aw_acc, w_acc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick(); n++;
      if (aw_acc) awvalid = 1'b0;
      if (w_acc)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
    end
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int unsigned n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic push_rx(input int unsigned ch, input logic [7:0] b);
    ch_rx_data[ch*8 +: 8] = b;
    ch_rx_valid[ch] = 1'b1;
    tick();
    ch_rx_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_handshake: got aw/w/ar/b/r=%b required 11100",
               {awready, wready, arready, bvalid, rvalid});
    end
    vectors++;
    if ({ch_cfg, ch_tx_valid, rdata, rresp, bresp} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: cfg=%h txv=%b rdata=%h rresp=%b bresp=%b required all 0",
               ch_cfg, ch_tx_valid, rdata, rresp, bresp);
    end
  endtask

  task automatic test_ctrl_strobe();
    logic [1:0] rsp; logic [31:0] d;
    axi_write(21'h020, 32'h0012_3405, 4'b0011, rsp);
    vectors++;
    if (rsp !== 2'b00 || ch_cfg[2*32 +: 32] !== 32'h0000_3405) begin
      miscompares++;
      $display("FAIL ctrl_lo_lanes: resp=%b cfg2=%h required 00 00003405", rsp, ch_cfg[2*32 +: 32]);
    end
    axi_write(21'h020, 32'h00BB_CCDD, 4'b1100, rsp);
    axi_read(21'h020, d, rsp);
    vectors++;
    if (rsp !== 2'b00 || d !== 32'h00BB_3405) begin
      miscompares++;
      $display("FAIL ctrl_hi_lanes: resp=%b data=%h required 00 00bb3405", rsp, d);
    end
  endtask

  task automatic test_tx();
    logic [1:0] rsp; logic [31:0] d;
    awaddr = 21'h004; wdata = 32'h0000_00A5; wstrb = 4'b0001; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    vectors++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL w_before_aw_ready: wready=%b awready=%b required 0 1", wready, awready);
    end
    repeat (2) tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || ch_tx_valid[0] !== 1'b1 || ch_tx_data[7:0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL tx_load: bvalid=%b bresp=%b txv=%b txd=%h required 1 00 1 a5",
               bvalid, bresp, ch_tx_valid[0], ch_tx_data[7:0]);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_write(21'h004, 32'h0000_005A, 4'b0001, rsp);
    vectors++;
    if (rsp !== 2'b10 || ch_tx_data[7:0] !== 8'hA5 || ch_tx_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_busy_write: resp=%b txd=%h txv=%b required 10 a5 1", rsp, ch_tx_data[7:0], ch_tx_valid[0]);
    end
    ch_tx_ready[0] = 1'b1;
    tick();
    ch_tx_ready[0] = 1'b0;
    vectors++;
    if (ch_tx_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_handshake_drop: txv=%b required 0", ch_tx_valid[0]);
    end
    axi_write(21'h004, 32'h0000_0077, 4'b0010, rsp);
    axi_read(21'h00C, d, rsp);
    vectors++;
    if (ch_tx_valid[0] !== 1'b0 || d !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL tx_no_strobe: txv=%b status=%h required 0 00000001", ch_tx_valid[0], d);
    end
  endtask

  task automatic test_rx_overflow();
    logic [1:0] rsp; logic [31:0] d;
    for (int i = 0; i < 9; i++) push_rx(1, 8'(8'h10 + i));
    axi_read(21'h01C, d, rsp);
    vectors++;
    if (rsp !== 2'b00 || d !== 32'h0000_0806) begin
      miscompares++;
      $display("FAIL rx_ovf_status: resp=%b status=%h required 00 00000806", rsp, d);
    end
    awaddr = 21'h01C; wdata = 32'h4; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    ch_rx_data[15:8] = 8'h99; ch_rx_valid[1] = 1'b1;
    tick();
    ch_rx_valid = '0;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(21'h01C, d, rsp);
    vectors++;
    if (d !== 32'h0000_0806) begin
      miscompares++;
      $display("FAIL ovf_clear_collision: status=%h required 00000806", d);
    end
    axi_write(21'h01C, 32'h4, 4'b0001, rsp);
    axi_read(21'h01C, d, rsp);
    vectors++;
    if (d !== 32'h0000_0802) begin
      miscompares++;
      $display("FAIL ovf_w1c: status=%h required 00000802", d);
    end
    for (int i = 0; i < 8; i++) begin
      axi_read(21'h018, d, rsp);
      vectors++;
      if (rsp !== 2'b00 || d !== (32'h8000_0010 + 32'(i))) begin
        miscompares++;
        $display("FAIL rx_pop_order[%0d]: resp=%b data=%h required 00 %h", i, rsp, d, 32'h8000_0010 + 32'(i));
      end
    end
    axi_read(21'h018, d, rsp);
    vectors++;
    if (rsp !== 2'b00 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL rx_empty_read: resp=%b data=%h required 00 00000000", rsp, d);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [1:0] rsp; logic [31:0] d;
    for (int i = 0; i < 8; i++) push_rx(1, 8'(8'h20 + i));
    araddr = 21'h018; arvalid = 1'b1;
    ch_rx_data[15:8] = 8'h28; ch_rx_valid[1] = 1'b1;
    tick();
    arvalid = 1'b0; ch_rx_valid = '0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'h8000_0020) begin
      miscompares++;
      $display("FAIL full_push_pop_data: rvalid=%b data=%h required 1 80000020", rvalid, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    axi_read(21'h01C, d, rsp);
    vectors++;
    if (d !== 32'h0000_0802) begin
      miscompares++;
      $display("FAIL full_push_pop_status: status=%h required 00000802", d);
    end
    for (int i = 0; i < 8; i++) begin
      axi_read(21'h018, d, rsp);
      vectors++;
      if (d !== (32'h8000_0021 + 32'(i))) begin
        miscompares++;
        $display("FAIL drain[%0d]: data=%h required %h", i, d, 32'h8000_0021 + 32'(i));
      end
    end
    araddr = 21'h018; arvalid = 1'b1;
    ch_rx_data[15:8] = 8'h3C; ch_rx_valid[1] = 1'b1;
    tick();
    arvalid = 1'b0; ch_rx_valid = '0;
    vectors++;
    if (rdata !== 32'h0 || rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_push_pop_data: data=%h resp=%b required 00000000 00", rdata, rresp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    axi_read(21'h01C, d, rsp);
    vectors++;
    if (d !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL empty_push_pop_status: status=%h required 00000100", d);
    end
  endtask

  task automatic test_decode_errors();
    logic [1:0] rsp; logic [31:0] d;
    axi_read(21'h0F0, d, rsp);
    vectors++;
    if (rsp !== 2'b10 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL read_unmapped: resp=%b data=%h required 10 00000000", rsp, d);
    end
    axi_write(21'h104, 32'h1234_5678, 4'hF, rsp);
    vectors++;
    if (rsp !== 2'b10) begin
      miscompares++;
      $display("FAIL write_unmapped: resp=%b required 10", rsp);
    end
    axi_read(21'h100, d, rsp);
    vectors++;
    if (rsp !== 2'b00 || d !== 32'hBC40_0001) begin
      miscompares++;
      $display("FAIL read_id: resp=%b data=%h required 00 bc400001", rsp, d);
    end
    axi_read(21'h004, d, rsp);
    vectors++;
    if (rsp !== 2'b10 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL read_tx_data: resp=%b data=%h required 10 00000000", rsp, d);
    end
    axi_read(21'h040, d, rsp);
    vectors++;
    if (rsp !== 2'b10) begin
      miscompares++;
      $display("FAIL read_ch_beyond_num: resp=%b required 10", rsp);
    end
    axi_write(21'h100, 32'h0, 4'hF, rsp);
    vectors++;
    if (rsp !== 2'b10) begin
      miscompares++;
      $display("FAIL write_id: resp=%b required 10", rsp);
    end
  endtask

  task automatic test_rready_stall();
    logic [1:0] rsp; logic [31:0] d;
    push_rx(3, 8'h11);
    push_rx(3, 8'h22);
    araddr = 21'h038; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'h8000_0011 || arready !== 1'b0) begin
        miscompares++;
        $display("FAIL rready_stall[%0d]: rvalid=%b data=%h arready=%b required 1 80000011 0",
                 i, rvalid, rdata, arready);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    axi_read(21'h03C, d, rsp);
    vectors++;
    if (d !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL stall_single_pop: status=%h required 00000100", d);
    end
    axi_read(21'h038, d, rsp);
    vectors++;
    if (d !== 32'h8000_0022) begin
      miscompares++;
      $display("FAIL stall_next_byte: data=%h required 80000022", d);
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 21'h000; wdata = 32'h0000_000F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    vectors++;
    if (bvalid !== 1'b1 || ch_cfg[31:0] !== 32'h0000_000F) begin
      miscompares++;
      $display("FAIL pre_reset_write: bvalid=%b cfg0=%h required 1 0000000f", bvalid, ch_cfg[31:0]);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (bvalid !== 1'b0 || ch_cfg !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: bvalid=%b cfg=%h required 0 0", bvalid, ch_cfg);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      miscompares++;
      $display("FAIL post_reset_ready: aw/w/ar/b=%b required 1110", {awready, wready, arready, bvalid});
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_strobe();
    test_tx();
    test_rx_overflow();
    test_push_pop_same_cycle();
    test_decode_errors();
    test_rready_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
